// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types and constants for the MAC result packer
package mac_pkg;

  // Bit positions inside the {NV,DZ,OF,UF,NX} exception flag vector
  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  // One output FIFO entry: packed word plus its tile/half markers
  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        half;
  } fifo_entry_t;

  // Pack FSM: nothing pending, one FP16 pending, one-cycle stall after a mode switch
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FLUSH = 2'd2
  } pack_state_t;

endpackage

// File: rtl/mac_sync_fifo.sv
// rtl/mac_sync_fifo.sv - small synchronous FIFO with full/empty status
module mac_sync_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_wr;
  logic          w_rd;

  // Writes into a full FIFO and reads from an empty one are ignored
  assign w_wr    = i_push && !o_full;
  assign w_rd    = i_pop && !o_empty;
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);

  // Head entry drives the outputs; zero when nothing is queued
  assign o_data  = o_empty ? '0 : r_mem[r_rptr];

  // Storage, pointers (power-of-two depth wraps naturally) and occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_rd) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mac_result_packer.sv
// rtl/mac_result_packer.sv - packs FP16 result pairs into 32-bit words with sticky flags
module mac_result_packer
  import mac_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int FLAG_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       in_data_i,
  input  logic              in_mode_i,
  input  logic              in_last_i,
  input  logic [FLAG_W-1:0] in_flags_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       out_data_o,
  output logic              out_last_o,
  output logic              out_half_o,
  input  logic              flags_clr_i,
  output logic [FLAG_W-1:0] flags_o
);

  pack_state_t       r_state;
  logic [15:0]       r_lo;
  logic [FLAG_W-1:0] r_flags;

  pack_state_t       w_state_nxt;
  logic              w_fire;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  fifo_entry_t       w_push_entry;
  fifo_entry_t       w_head;

  // A presented input only counts as accepted when the FSM actually consumes it;
  // in HALF a mode-1 input sees ready high but is held back for the flush
  assign in_ready_o = !rst_i && !w_fifo_full && (r_state != ST_FLUSH);
  assign w_fire     = in_valid_i && in_ready_o;
  assign w_pop      = out_valid_o && out_ready_i;

  // Pack decision: what to push, whether the input is consumed, next state
  always_comb begin
    w_accept     = 1'b0;
    w_push       = 1'b0;
    w_push_entry = '0;
    w_state_nxt  = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_fire) begin
          w_accept = 1'b1;
          if (in_mode_i) begin
            w_push            = 1'b1;
            w_push_entry.data = in_data_i;
            w_push_entry.last = in_last_i;
            w_push_entry.half = 1'b0;
          end else if (in_last_i) begin
            w_push            = 1'b1;
            w_push_entry.data = {16'h0000, in_data_i[15:0]};
            w_push_entry.last = 1'b1;
            w_push_entry.half = 1'b1;
          end else begin
            w_state_nxt = ST_HALF;
          end
        end
      end
      ST_HALF: begin
        if (w_fire) begin
          w_push = 1'b1;
          if (!in_mode_i) begin
            w_accept          = 1'b1;
            w_push_entry.data = {in_data_i[15:0], r_lo};
            w_push_entry.last = in_last_i;
            w_push_entry.half = 1'b0;
            w_state_nxt       = ST_EMPTY;
          end else begin
            w_push_entry.data = {16'h0000, r_lo};
            w_push_entry.last = 1'b0;
            w_push_entry.half = 1'b1;
            w_state_nxt       = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // Pack state and the pending low half
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_EMPTY;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_EMPTY && w_accept && !in_mode_i && !in_last_i) begin
        r_lo <= in_data_i[15:0];
      end
    end
  end

  // Sticky exception flags: only consumed inputs contribute; clear takes effect first
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_flags <= '0;
    end else if (w_accept) begin
      r_flags <= (flags_clr_i ? '0 : r_flags) | in_flags_i;
    end else if (flags_clr_i) begin
      r_flags <= '0;
    end
  end

  assign flags_o = r_flags;

  mac_sync_fifo #(
    .W     ($bits(fifo_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign out_valid_o = !w_fifo_empty;
  assign out_data_o  = w_head.data;
  assign out_last_o  = w_head.last;
  assign out_half_o  = w_head.half;

endmodule

// File: tb/tb_mac_result_packer.sv
// tb/tb_mac_result_packer.sv - directed self-checking bench for mac_result_packer
module tb_mac_result_packer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_data_i;
  logic        in_mode_i;
  logic        in_last_i;
  logic [4:0]  in_flags_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_data_o;
  logic        out_last_o;
  logic        out_half_o;
  logic        flags_clr_i;
  logic [4:0]  flags_o;

  int n_checks = 0;
  int n_fails  = 0;

  mac_result_packer #(.DEPTH(2), .FLAG_W(5)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_mode_i   (in_mode_i),
    .in_last_i   (in_last_i),
    .in_flags_i  (in_flags_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .out_half_o  (out_half_o),
    .flags_clr_i (flags_clr_i),
    .flags_o     (flags_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] d, input logic m,
                        input logic l, input logic [4:0] f);
    in_valid_i = v;
    in_data_i  = d;
    in_mode_i  = m;
    in_last_i  = l;
    in_flags_i = f;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] d,
                           input logic l, input logic h);
    check_eq({tag, ".valid"}, 32'(out_valid_o), 32'(v));
    if (v) begin
      check_eq({tag, ".data"}, out_data_o, d);
      check_eq({tag, ".last"}, 32'(out_last_o), 32'(l));
      check_eq({tag, ".half"}, 32'(out_half_o), 32'(h));
    end
  endtask

  initial begin
    rst_i       = 1'b1;
    out_ready_i = 1'b1;
    flags_clr_i = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 5'b0);
    #1;
    check_eq("rst.in_ready", 32'(in_ready_o), 32'd0);
    check_eq("rst.out_valid", 32'(out_valid_o), 32'd0);
    check_eq("rst.out_data", out_data_o, 32'h0);
    check_eq("rst.flags", 32'(flags_o), 32'd0);
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    check_eq("idle.in_ready", 32'(in_ready_o), 32'd1);

    // FP16 stream of four, pairs appear one cycle after the completing input
    set_in(1'b1, 32'h0000_3C00, 1'b0, 1'b0, 5'b0); tick();
    check_out("s1.a", 1'b0, 32'h0, 1'b0, 1'b0);
    set_in(1'b1, 32'h0000_4000, 1'b0, 1'b0, 5'b0); tick();
    check_out("s1.b", 1'b1, 32'h4000_3C00, 1'b0, 1'b0);
    set_in(1'b1, 32'h0000_4200, 1'b0, 1'b0, 5'b0); tick();
    check_out("s1.c", 1'b0, 32'h0, 1'b0, 1'b0);
    set_in(1'b1, 32'h0000_4400, 1'b0, 1'b1, 5'b0); tick();
    check_out("s1.d", 1'b1, 32'h4400_4200, 1'b1, 1'b0);
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 5'b0); tick();
    check_out("s1.e", 1'b0, 32'h0, 1'b0, 1'b0);

    // last closes a pair, then a lone last emits a half word
    set_in(1'b1, 32'h0000_3C00, 1'b0, 1'b0, 5'b0); tick();
    set_in(1'b1, 32'h0000_3800, 1'b0, 1'b1, 5'b0); tick();
    check_out("s2.a", 1'b1, 32'h3800_3C00, 1'b1, 1'b0);
    set_in(1'b1, 32'hABCD_3400, 1'b0, 1'b1, 5'b0); tick();
    check_out("s2.b", 1'b1, 32'h0000_3400, 1'b1, 1'b1);
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 5'b0); tick();
    check_out("s2.c", 1'b0, 32'h0, 1'b0, 1'b0);

    // mode switch while a half is pending: flush half, one-cycle gap, then FP32
    set_in(1'b1, 32'h0000_BC00, 1'b0, 1'b0, 5'b0); tick();
    check_eq("s3.ready_half", 32'(in_ready_o), 32'd1);
    set_in(1'b1, 32'h3F80_0000, 1'b1, 1'b0, 5'b0); tick();
    check_out("s3.flush", 1'b1, 32'h0000_BC00, 1'b0, 1'b1);
    check_eq("s3.ready_flush", 32'(in_ready_o), 32'd0);
    tick();
    check_out("s3.gap", 1'b0, 32'h0, 1'b0, 1'b0);
    check_eq("s3.ready_after", 32'(in_ready_o), 32'd1);
    tick();
    check_out("s3.fp32", 1'b1, 32'h3F80_0000, 1'b0, 1'b0);
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 5'b0); tick();
    check_out("s3.end", 1'b0, 32'h0, 1'b0, 1'b0);

    // FP32 backpressure with a two-entry FIFO
    out_ready_i = 1'b0;
    set_in(1'b1, 32'h1111_1111, 1'b1, 1'b0, 5'b0); tick();
    check_eq("s4.ready1", 32'(in_ready_o), 32'd1);
    set_in(1'b1, 32'h2222_2222, 1'b1, 1'b0, 5'b0); tick();
    check_eq("s4.ready2", 32'(in_ready_o), 32'd0);
    check_out("s4.head1", 1'b1, 32'h1111_1111, 1'b0, 1'b0);
    set_in(1'b1, 32'h3333_3333, 1'b1, 1'b1, 5'b0); tick();
    check_out("s4.stall", 1'b1, 32'h1111_1111, 1'b0, 1'b0);
    check_eq("s4.ready3", 32'(in_ready_o), 32'd0);
    out_ready_i = 1'b1;
    tick();
    check_out("s4.w2", 1'b1, 32'h2222_2222, 1'b0, 1'b0);
    check_eq("s4.ready4", 32'(in_ready_o), 32'd1);
    tick();
    check_out("s4.w3", 1'b1, 32'h3333_3333, 1'b1, 1'b0);
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 5'b0); tick();
    check_out("s4.drain", 1'b0, 32'h0, 1'b0, 1'b0);

    // sticky flags: accumulate, clear-with-accept, stalled input ignored
    set_in(1'b1, 32'h0000_0001, 1'b1, 1'b0, 5'b00100); tick();
    check_eq("s5.f1", 32'(flags_o), 32'(5'b00100));
    set_in(1'b1, 32'h0000_0002, 1'b1, 1'b0, 5'b00001); tick();
    check_eq("s5.f2", 32'(flags_o), 32'(5'b00101));
    flags_clr_i = 1'b1;
    set_in(1'b1, 32'h0000_0003, 1'b1, 1'b0, 5'b10000); tick();
    flags_clr_i = 1'b0;
    check_eq("s5.f3", 32'(flags_o), 32'(5'b10000));
    out_ready_i = 1'b0;
    set_in(1'b1, 32'h0000_0004, 1'b1, 1'b0, 5'b00000); tick();
    check_eq("s5.full", 32'(in_ready_o), 32'd0);
    set_in(1'b1, 32'h0000_0005, 1'b1, 1'b0, 5'b01000); tick();
    check_eq("s5.stalled", 32'(flags_o), 32'(5'b10000));
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 5'b0);
    out_ready_i = 1'b1;
    tick();
    tick();
    check_out("s5.drain", 1'b0, 32'h0, 1'b0, 1'b0);
    flags_clr_i = 1'b1; tick();
    flags_clr_i = 1'b0;
    check_eq("s5.clr", 32'(flags_o), 32'd0);

    // asynchronous reset mid-tile discards queued and pending data
    out_ready_i = 1'b0;
    set_in(1'b1, 32'h5555_5555, 1'b1, 1'b0, 5'b00010); tick();
    set_in(1'b1, 32'h0000_4800, 1'b0, 1'b0, 5'b0); tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 5'b0);
    check_out("s6.pre", 1'b1, 32'h5555_5555, 1'b0, 1'b0);
    #2;
    rst_i = 1'b1;
    #1;
    check_eq("s6.rst_valid", 32'(out_valid_o), 32'd0);
    check_eq("s6.rst_data", out_data_o, 32'h0);
    check_eq("s6.rst_ready", 32'(in_ready_o), 32'd0);
    check_eq("s6.rst_flags", 32'(flags_o), 32'd0);
    tick();
    rst_i = 1'b0;
    out_ready_i = 1'b1;
    tick();
    set_in(1'b1, 32'h0000_3C00, 1'b0, 1'b1, 5'b0); tick();
    check_out("s6.post", 1'b1, 32'h0000_3C00, 1'b1, 1'b1);
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 5'b0); tick();
    check_out("s6.nostale", 1'b0, 32'h0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mac_result_packer.md
Name: mac_result_packer

Overview:
- Sits directly downstream of the FP32→FP16 conversion stage in the MAC result path; consumes its 32-bit result word plus the five IEEE exception flags.
- In FP16 mode (mode=0), packs two consecutive FP16 results into one 32-bit word. In FP32 mode (mode=1), forwards the word unchanged.
- Output is buffered in a small FIFO behind a valid/ready handshake toward the writeback/store stage.
- Exception flags are accumulated into sticky status bits.

Parameters:
- DEPTH, 2, output FIFO entries; power of two, ≥2.
- FLAG_W, 5, exception flag width, ordered {NV,DZ,OF,UF,NX}.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- in_valid_i  in  1  upstream result valid.
- in_ready_o  out  1  block can accept this cycle.
- in_data_i  in  32  result; FP16 in bits [15:0] when in_mode_i=0.
- in_mode_i  in  1  0=FP16 pack, 1=FP32 passthrough.
- in_last_i  in  1  final result of a tile; forces a flush of any pending half.
- in_flags_i  in  FLAG_W  {NV,DZ,OF,UF,NX} for this result.
- out_valid_o  out  1  packed word available.
- out_ready_i  in  1  downstream accepts.
- out_data_o  out  32  packed word.
- out_last_o  out  1  word closes a tile.
- out_half_o  out  1  word holds only one valid FP16, in [15:0].
- flags_clr_i  in  1  clear sticky flags.
- flags_o  out  FLAG_W  sticky exception flags.

Behaviour:
- Reset values: out_valid_o=0, in_ready_o=0 while rst_i is high, out_data_o=0, out_last_o=0, out_half_o=0, flags_o=0. The pack state returns to EMPTY, the pending half is cleared, and the FIFO is emptied.
- Reset asserted mid-tile discards the pending half and all FIFO contents. No partial word is emitted.
- Accept: an input is accepted on a cycle where in_valid_i and in_ready_o are both high.
- in_ready_o = !fifo_full && state != FLUSH.
- Pack FSM states: EMPTY, HALF, FLUSH.
  - EMPTY, mode=1 accept: push {data, last, half=0}. Stay EMPTY.
  - EMPTY, mode=0 accept, last=0: latch data[15:0] as lo. Go to HALF, no push.
  - EMPTY, mode=0 accept, last=1: push {16'h0, data[15:0]}, last=1, half=1. Stay EMPTY.
  - HALF, mode=0 accept: push {data[15:0], lo}, last=in_last_i, half=0. Go to EMPTY.
  - HALF, mode=1 input presented (mode switch): in_ready_o stays high, but the input is NOT accepted. Instead, push {16'h0, lo}, last=0, half=1, and go to FLUSH for one cycle. The input is accepted later from EMPTY.
  - FLUSH is therefore only a one-cycle stall state. FLUSH → EMPTY unconditionally; no push.
  - A push is only performed when the FIFO is not full. HALF with mode=1 and a full FIFO waits in HALF.
- Upper half of every word packed in FP16 mode: in_data_i[31:16] is ignored (the converter zero-pads it).
- FIFO:
  - Synchronous write and read. A word pushed in cycle N is visible on out_valid_o/out_data_o in cycle N+1 (latency 1 from accept of the completing input).
  - Pop occurs when out_valid_o && out_ready_i.
  - Simultaneous push and pop when full is not allowed, because in_ready_o deasserts when full.
  - Simultaneous push and pop when non-empty keeps the count.
  - Pointers wrap modulo DEPTH.
  - out_* outputs are driven from the head entry and are held stable while out_valid_o && !out_ready_i.
- Throughput: one input per cycle when downstream is always ready. No bubbles except the FLUSH cycle.
- Sticky flags: on each accept, flags_o <= (flags_clr_i ? 0 : flags_o) | in_flags_i. flags_clr_i without an accept clears flags_o to 0. The clear and the new flags in the same cycle leave only the new flags.
- Flags of an input that is stalled (not accepted) are not recorded.

Decomposition:
- Shared package mac_pkg holds:
  - flag index localparams: FLG_NV=4, FLG_DZ=3, FLG_OF=2, FLG_UF=1, FLG_NX=0;
  - a typedef for the packed FIFO entry {data[31:0], last, half};
  - a typedef for the pack-state enum.
- One sub-module: mac_sync_fifo (parameterised width/DEPTH, full/empty outputs). The pack FSM and sticky flags live in the top module.

Test Plan:
- Mode 0 stream of 3C00, 4000, 4200, 4400 (last on 4400), out_ready=1 → words 0x40003C00 (last=0, half=0) then 0x44004200 (last=1); each word appears 1 cycle after its second input.
- Mode 0 sequence 3C00, then 3800 with last=1, then 3400 with last=1 → 0x38003C00 (last=1), then 0x00003400 (last=1, half=1).
- Mode 0 input 0xBC00, then mode 1 input 0x3F800000 → 0x0000BC00 (half=1), then a one-cycle in_ready_o/no-accept FLUSH gap, then 0x3F800000 (half=0).
- FP32 backpressure: out_ready=0 with 3 FP32 inputs, DEPTH=2 → in_ready_o drops after 2 accepts. Raising out_ready yields all 3 words in order with no loss or duplication, and out_data_o stays stable while stalled.
- Flags: accept with flags 5'b00100, then 5'b00001 → flags_o=5'b00101. Then flags_clr_i together with an accept of 5'b10000 → flags_o=5'b10000. A stalled input carrying 5'b01000 leaves flags_o unchanged.
- Reset: assert rst_i asynchronously while in HALF with 1 FIFO entry → outputs zero immediately. After release, input 0x3C00 with last=1 emits only 0x00003C00, with no stale data.
